// File: rtl/ddr3_app_sequencer.sv
// ddr3_app_sequencer
// Burst sequencer between the USB-side FIFOs and the DDR3 controller's native
// application interface. A write request drains wr_cnt 256-bit words from the
// first-word-fall-through write FIFO into consecutive bursts. A read request
// issues rd_cnt read commands under a credit limit and forwards the returned
// words into the read FIFO.
//
// Ports
//   clk, sys_rst (async assert, active-low)
//   init_calib_complete     : starts are ignored while low
//   wr_start/wr_base_addr/wr_cnt, rd_start/rd_base_addr/rd_cnt : requests
//   wf_empty/wf_dout/wf_rd_en                  : write FIFO side
//   app_* (rdy, wdf_rdy, en, cmd, addr, wdf_*, rd_data*) : controller side
//   rf_prog_full/rf_din/rf_wr_en               : read FIFO side
//   busy, done                                 : status
//   wr_beats_total, rd_beats_total             : statistics
//
// Build option: define DDR3_SEQ_STATS_EN to build the 32-bit beat counters;
// otherwise both statistics ports are tied to 0.
module ddr3_app_sequencer #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int ADDR_STEP  = 8,
  parameter int RD_CREDITS = 16
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,
  input  logic                wr_start,
  input  logic [ADDR_W-1:0]   wr_base_addr,
  input  logic [5:0]          wr_cnt,
  input  logic                rd_start,
  input  logic [ADDR_W-1:0]   rd_base_addr,
  input  logic [5:0]          rd_cnt,
  input  logic                wf_empty,
  input  logic [DATA_W-1:0]   wf_dout,
  output logic                wf_rd_en,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                rf_prog_full,
  output logic [DATA_W-1:0]   rf_din,
  output logic                rf_wr_en,
  output logic                busy,
  output logic                done,
  output logic [31:0]         wr_beats_total,
  output logic [31:0]         rd_beats_total
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_DRAIN} state_t;

  localparam logic [6:0]        CREDITS = 7'(RD_CREDITS);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [5:0]          remaining_reg, remaining_next;
  logic [6:0]          outstanding_reg, outstanding_next;
  logic                done_reg, done_next;
  logic [DATA_W-1:0]   rf_din_reg;
  logic                rf_wr_en_reg;
  logic                fire, issue, rd_fwd, rd_state;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      done_reg        <= 1'b0;
      rf_din_reg      <= '0;
      rf_wr_en_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      outstanding_reg <= outstanding_next;
      done_reg        <= done_next;
      rf_wr_en_reg    <= rd_fwd;
      if (rd_fwd) begin
        rf_din_reg <= app_rd_data;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    remaining_next   = remaining_reg;
    outstanding_next = outstanding_reg;
    done_next        = 1'b0;
    fire             = 1'b0;
    issue            = 1'b0;
    rd_state         = (state_reg == READ) || (state_reg == RD_DRAIN);
    // Returned data is only ours while a read is in progress; anything
    // arriving in IDLE/WRITE belongs to an aborted read and is dropped.
    rd_fwd           = app_rd_data_valid && rd_state;

    case (state_reg)
      IDLE: begin
        if (init_calib_complete && wr_start) begin
          if (wr_cnt == '0) begin
            done_next = 1'b1;
          end else begin
            state_next     = WRITE;
            addr_next      = wr_base_addr;
            remaining_next = wr_cnt;
          end
        end else if (init_calib_complete && rd_start) begin
          if (rd_cnt == '0) begin
            done_next = 1'b1;
          end else begin
            state_next     = READ;
            addr_next      = rd_base_addr;
            remaining_next = rd_cnt;
          end
        end
      end
      WRITE: begin
        fire = app_rdy && app_wdf_rdy && !wf_empty;
        if (fire) begin
          addr_next      = addr_reg + STEP;
          remaining_next = remaining_reg - 6'd1;
          if (remaining_reg == 6'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      READ: begin
        issue = app_rdy && (outstanding_reg < CREDITS) && !rf_prog_full;
        if (issue) begin
          addr_next      = addr_reg + STEP;
          remaining_next = remaining_reg - 6'd1;
          if (remaining_reg == 6'd1) begin
            state_next = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if ((outstanding_reg == 7'd0) || ((outstanding_reg == 7'd1) && rd_fwd)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Saturating decrement guards against a stray valid with nothing pending.
    case ({issue, rd_fwd && (outstanding_reg != 7'd0)})
      2'b10:   outstanding_next = outstanding_reg + 7'd1;
      2'b01:   outstanding_next = outstanding_reg - 7'd1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  assign app_en       = fire | issue;
  assign app_cmd      = rd_state ? 3'b001 : 3'b000;
  assign app_addr     = addr_reg;
  assign app_wdf_data = wf_dout;
  assign app_wdf_wren = fire;
  assign app_wdf_end  = fire;
  assign app_wdf_mask = '0;
  assign wf_rd_en     = fire;
  assign rf_din       = rf_din_reg;
  assign rf_wr_en     = rf_wr_en_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;

`ifdef DDR3_SEQ_STATS_EN
  logic [31:0] wr_beats_reg, rd_beats_reg;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_beats_reg <= '0;
      rd_beats_reg <= '0;
    end else begin
      if (fire) begin
        wr_beats_reg <= wr_beats_reg + 32'd1;
      end
      if (rd_fwd) begin
        rd_beats_reg <= rd_beats_reg + 32'd1;
      end
    end
  end

  assign wr_beats_total = wr_beats_reg;
  assign rd_beats_total = rd_beats_reg;
`else
  assign wr_beats_total = 32'd0;
  assign rd_beats_total = 32'd0;
`endif

endmodule
